// File: rtl/vexriscv_bus_bridge_pkg.sv
// Shared types and helpers for the VexRiscv bus bridge: routing-FIFO entry
// layout, request source and access-size encodings, and write-lane helpers.
package vexriscv_bridge_pkg;

   typedef enum logic {
      SRC_IBUS = 1'b0,
      SRC_DBUS = 1'b1
   } src_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;

   // One entry per accepted request still waiting for its response.
   typedef struct packed {
      src_t src;
      logic is_write;
      logic local_err;
   } route_entry_t;

   // Byte strobes for a dBus access of the given size at the given byte offset.
   function automatic logic [3:0] size_to_wstrb(logic [1:0] size, logic [1:0] addr_lo);
      case (size)
         SIZE_BYTE: return 4'b0001 << addr_lo;
         SIZE_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
         default:   return 4'hF;
      endcase
   endfunction

   // Replicate narrow write data across all byte lanes.
   function automatic logic [31:0] replicate_wdata(logic [1:0] size, logic [31:0] data);
      case (size)
         SIZE_BYTE: return {4{data[7:0]}};
         SIZE_HALF: return {2{data[15:0]}};
         default:   return data;
      endcase
   endfunction

endpackage

// File: rtl/vexriscv_bus_bridge_if.sv
// Bus interfaces of the bridge: the core-facing iBus/dBus pair and the
// downstream memory-mapped request/response port.

// Core side: master = VexRiscv core, slave = bridge.
interface vexriscv_core_if;
   logic        ibus_cmd_valid;
   logic        ibus_cmd_ready;
   logic [31:0] ibus_cmd_pc;
   logic        ibus_rsp_valid;
   logic        ibus_rsp_error;
   logic [31:0] ibus_rsp_inst;
   logic        dbus_cmd_valid;
   logic        dbus_cmd_ready;
   logic        dbus_cmd_wr;
   logic [31:0] dbus_cmd_address;
   logic [31:0] dbus_cmd_data;
   logic [1:0]  dbus_cmd_size;
   logic        dbus_rsp_valid;
   logic        dbus_rsp_error;
   logic [31:0] dbus_rsp_data;

   modport master (
      output ibus_cmd_valid, ibus_cmd_pc,
      input  ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error, ibus_rsp_inst,
      output dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size,
      input  dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_error, dbus_rsp_data
   );

   modport slave (
      input  ibus_cmd_valid, ibus_cmd_pc,
      output ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error, ibus_rsp_inst,
      input  dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size,
      output dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_error, dbus_rsp_data
   );
endinterface

// Downstream side: master = bridge, slave = SoC interconnect.
interface vexriscv_mem_if #(parameter int ADDR_WIDTH = 32);
   logic                  m_req_valid;
   logic                  m_req_ready;
   logic [ADDR_WIDTH-1:0] m_req_addr;
   logic                  m_req_we;
   logic [31:0]           m_req_wdata;
   logic [3:0]            m_req_wstrb;
   logic                  m_rsp_valid;
   logic                  m_rsp_error;
   logic [31:0]           m_rsp_rdata;

   modport master (
      output m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wstrb,
      input  m_req_ready, m_rsp_valid, m_rsp_error, m_rsp_rdata
   );

   modport slave (
      input  m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wstrb,
      output m_req_ready, m_rsp_valid, m_rsp_error, m_rsp_rdata
   );
endinterface

// File: rtl/vexriscv_bus_bridge_fifo.sv
// Small synchronous FIFO with occupancy count, used to remember where each
// in-flight response must be routed. Push when full and pop when empty are ignored.
module bridge_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 3
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] slots [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign empty   = (count == '0);
   assign rdata   = slots[rptr];

   // Storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) slots[wptr] <= wdata;
   end

   // Wrapping pointers and occupancy count; a simultaneous push and pop keeps count.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
         if (do_pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/vexriscv_bus_bridge.sv
// VexRiscv bus bridge: arbitrates iBus/dBus onto one in-order downstream port,
// answers out-of-window accesses locally, routes responses back to the
// requesting bus and registers the interrupt lines toward the core.
module vexriscv_bus_bridge
   import vexriscv_bridge_pkg::*;
#(
   parameter int          ADDR_WIDTH      = 32,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          ARB_MODE        = 0,
   parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
   parameter logic [31:0] ADDR_SIZE       = 32'h8000_0000,
   parameter int          IRQ_SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            arst,
   vexriscv_core_if.slave  core,
   vexriscv_mem_if.master  down,
   input  logic            irq_ext_i,
   input  logic            irq_timer_i,
   input  logic            irq_sw_i,
   output logic            irq_ext_o,
   output logic            irq_timer_o,
   output logic            irq_sw_o,
   output logic            err_wr_drop_o,
   output logic            err_spurious_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int EW = $bits(route_entry_t);

   logic [CW-1:0]  count;
   logic           fifo_empty;
   logic           full;
   logic [EW-1:0]  head_raw;
   route_entry_t   head;
   route_entry_t   push_entry;
   src_t           rr_prio;

   logic           grant_d;
   logic           grant_i;
   logic           gvalid;
   logic           gready;
   logic           accept;
   logic           push;
   logic           pop;
   logic           spurious;
   logic           deliver;
   logic           sel_wr;
   logic           sel_legal;
   logic [31:0]    sel_addr;
   logic [31:0]    sel_wdata;
   logic [3:0]     sel_wstrb;
   logic [32:0]    sel_offset;

   logic [IRQ_SYNC_STAGES-1:0] ext_sync;

   // Pick one requester per cycle; in round-robin mode rr_prio names the favoured source.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (core.dbus_cmd_valid && core.ibus_cmd_valid) begin
         if (ARB_MODE == 1 && rr_prio == SRC_IBUS) grant_i = 1'b1;
         else                                      grant_d = 1'b1;
      end else begin
         grant_d = core.dbus_cmd_valid;
         grant_i = core.ibus_cmd_valid;
      end
   end

   // Mux the granted command; fetches are always full-word reads.
   always_comb begin
      sel_addr  = core.ibus_cmd_pc;
      sel_wr    = 1'b0;
      sel_wdata = '0;
      sel_wstrb = 4'hF;
      if (grant_d) begin
         sel_addr  = core.dbus_cmd_address;
         sel_wr    = core.dbus_cmd_wr;
         sel_wdata = replicate_wdata(core.dbus_cmd_size, core.dbus_cmd_data);
         sel_wstrb = size_to_wstrb(core.dbus_cmd_size, core.dbus_cmd_address[1:0]);
      end
   end

   // Offset arithmetic in 33 bits so a window ending at 2^32 still works.
   assign sel_offset = {1'b0, sel_addr} - {1'b0, ADDR_BASE};
   assign sel_legal  = (sel_addr >= ADDR_BASE) && (sel_offset < {1'b0, ADDR_SIZE});

   assign full   = (count >= CW'(MAX_OUTSTANDING));
   assign gvalid = grant_d || grant_i;
   assign gready = !full && (!sel_legal || down.m_req_ready);
   assign accept = gvalid && gready;
   assign push   = accept && !(sel_wr && !sel_legal);

   assign core.dbus_cmd_ready = grant_d && gready;
   assign core.ibus_cmd_ready = grant_i && gready;

   assign down.m_req_valid = gvalid && sel_legal && !full;
   assign down.m_req_addr  = ADDR_WIDTH'(sel_addr);
   assign down.m_req_we    = sel_wr;
   assign down.m_req_wdata = sel_wdata;
   assign down.m_req_wstrb = sel_wstrb;

   assign push_entry = '{src: (grant_d ? SRC_DBUS : SRC_IBUS), is_write: sel_wr, local_err: !sel_legal};
   assign head       = route_entry_t'(head_raw);

   // Local errors retire on their own; real entries wait for the downstream response.
   assign pop      = !fifo_empty && (head.local_err || down.m_rsp_valid);
   assign spurious = down.m_rsp_valid && (fifo_empty || head.local_err);
   assign deliver  = pop && (head.local_err || !head.is_write);

   bridge_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (EW)
   ) u_route_fifo (
      .clk   (clk),
      .arst  (arst),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head_raw),
      .empty (fifo_empty),
      .count (count)
   );

   // Round-robin pointer moves only when a command is actually accepted.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst)       rr_prio <= SRC_DBUS;
      else if (accept) rr_prio <= grant_d ? SRC_IBUS : SRC_DBUS;
   end

   // Registered one-cycle responses toward the core, steered by the head entry's source.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         core.ibus_rsp_valid <= 1'b0;
         core.ibus_rsp_error <= 1'b0;
         core.ibus_rsp_inst  <= '0;
         core.dbus_rsp_valid <= 1'b0;
         core.dbus_rsp_error <= 1'b0;
         core.dbus_rsp_data  <= '0;
      end else begin
         core.ibus_rsp_valid <= 1'b0;
         core.ibus_rsp_error <= 1'b0;
         core.ibus_rsp_inst  <= '0;
         core.dbus_rsp_valid <= 1'b0;
         core.dbus_rsp_error <= 1'b0;
         core.dbus_rsp_data  <= '0;
         if (deliver) begin
            if (head.src == SRC_IBUS) begin
               core.ibus_rsp_valid <= 1'b1;
               core.ibus_rsp_error <= head.local_err ? 1'b1 : down.m_rsp_error;
               core.ibus_rsp_inst  <= head.local_err ? '0 : down.m_rsp_rdata;
            end else begin
               core.dbus_rsp_valid <= 1'b1;
               core.dbus_rsp_error <= head.local_err ? 1'b1 : down.m_rsp_error;
               core.dbus_rsp_data  <= head.local_err ? '0 : down.m_rsp_rdata;
            end
         end
      end
   end

   // Error pulses: dropped out-of-window writes and responses nobody is waiting for.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         err_wr_drop_o  <= 1'b0;
         err_spurious_o <= 1'b0;
      end else begin
         err_wr_drop_o  <= accept && sel_wr && !sel_legal;
         err_spurious_o <= spurious;
      end
   end

   // External interrupt is asynchronous to clk and gets a full synchroniser chain.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) ext_sync <= '0;
      else       ext_sync <= {ext_sync[IRQ_SYNC_STAGES-2:0], irq_ext_i};
   end

   // Timer and software interrupts are already in this clock domain; one register suffices.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         irq_timer_o <= 1'b0;
         irq_sw_o    <= 1'b0;
      end else begin
         irq_timer_o <= irq_timer_i;
         irq_sw_o    <= irq_sw_i;
      end
   end

   assign irq_ext_o = ext_sync[IRQ_SYNC_STAGES-1];

endmodule

// File: tb/tb_vexriscv_bus_bridge.sv
// Directed self-checking bench for vexriscv_bus_bridge: a round-robin instance
// carries most checks, a fixed-priority twin shares its inputs for arbitration.
module tb_vexriscv_bus_bridge;

   logic clk;
   logic arst;
   logic irqExt, irqTimer, irqSw;
   logic irqExtOut, irqTimerOut, irqSwOut, errWrDrop, errSpurious;
   logic irqExtOut0, irqTimerOut0, irqSwOut0, errWrDrop0, errSpurious0;
   int   checkCount;
   int   failCount;
   int   accepted;

   vexriscv_core_if                   c ();
   vexriscv_mem_if #(.ADDR_WIDTH(32)) m ();
   vexriscv_core_if                   c0 ();
   vexriscv_mem_if #(.ADDR_WIDTH(32)) m0 ();

   // The fixed-priority twin sees exactly the same stimulus as the main DUT.
   assign c0.ibus_cmd_valid   = c.ibus_cmd_valid;
   assign c0.ibus_cmd_pc      = c.ibus_cmd_pc;
   assign c0.dbus_cmd_valid   = c.dbus_cmd_valid;
   assign c0.dbus_cmd_wr      = c.dbus_cmd_wr;
   assign c0.dbus_cmd_address = c.dbus_cmd_address;
   assign c0.dbus_cmd_data    = c.dbus_cmd_data;
   assign c0.dbus_cmd_size    = c.dbus_cmd_size;
   assign m0.m_req_ready      = m.m_req_ready;
   assign m0.m_rsp_valid      = m.m_rsp_valid;
   assign m0.m_rsp_error      = m.m_rsp_error;
   assign m0.m_rsp_rdata      = m.m_rsp_rdata;

   vexriscv_bus_bridge #(.ARB_MODE(1)) dut (
      .clk            (clk),
      .arst           (arst),
      .core           (c),
      .down           (m),
      .irq_ext_i      (irqExt),
      .irq_timer_i    (irqTimer),
      .irq_sw_i       (irqSw),
      .irq_ext_o      (irqExtOut),
      .irq_timer_o    (irqTimerOut),
      .irq_sw_o       (irqSwOut),
      .err_wr_drop_o  (errWrDrop),
      .err_spurious_o (errSpurious)
   );

   vexriscv_bus_bridge #(.ARB_MODE(0)) dut0 (
      .clk            (clk),
      .arst           (arst),
      .core           (c0),
      .down           (m0),
      .irq_ext_i      (irqExt),
      .irq_timer_i    (irqTimer),
      .irq_sw_i       (irqSw),
      .irq_ext_o      (irqExtOut0),
      .irq_timer_o    (irqTimerOut0),
      .irq_sw_o       (irqSwOut0),
      .err_wr_drop_o  (errWrDrop0),
      .err_spurious_o (errSpurious0)
   );

   // Free-running core clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout required normal end");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h required 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [31:0] ipc, input logic dv, input logic dwr,
                                input logic [31:0] daddr, input logic [31:0] ddata, input logic [1:0] dsize);
      c.ibus_cmd_valid   = iv;
      c.ibus_cmd_pc      = ipc;
      c.dbus_cmd_valid   = dv;
      c.dbus_cmd_wr      = dwr;
      c.dbus_cmd_address = daddr;
      c.dbus_cmd_data    = ddata;
      c.dbus_cmd_size    = dsize;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Main directed sequence.
   initial begin
      checkCount    = 0;
      failCount     = 0;
      arst          = 1'b0;
      irqExt        = 1'b0;
      irqTimer      = 1'b0;
      irqSw         = 1'b0;
      m.m_req_ready = 1'b0;
      m.m_rsp_valid = 1'b0;
      m.m_rsp_error = 1'b0;
      m.m_rsp_rdata = '0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      #3;
      checkOutput("reset_ibus_rsp", c.ibus_rsp_valid, 0);
      checkOutput("reset_dbus_rsp", c.dbus_rsp_valid, 0);
      checkOutput("reset_irq_ext", irqExtOut, 0);
      checkOutput("reset_spurious", errSpurious, 0);
      checkOutput("reset_wr_drop", errWrDrop, 0);
      #9 arst = 1'b1;
      tick;

      // Both buses request every cycle: RR alternates D,I,D,I; fixed always grants D.
      m.m_req_ready = 1'b1;
      applyStimulus(1, 32'h40, 1, 0, 32'h80, 0, 2);
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("rr_dgrant", c.dbus_cmd_ready, (k % 2 == 0));
         checkOutput("rr_igrant", c.ibus_cmd_ready, (k % 2 == 1));
         checkOutput("fx_dgrant", c0.dbus_cmd_ready, 1);
         checkOutput("fx_igrant", c0.ibus_cmd_ready, 0);
         tick;
      end
      #1;
      checkOutput("rr_full_dready", c.dbus_cmd_ready, 0);
      checkOutput("rr_full_mreq", m.m_req_valid, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         m.m_rsp_valid = 1'b1;
         m.m_rsp_rdata = 32'h1000 + k;
         tick;
         checkOutput("rr_drain_dvalid", c.dbus_rsp_valid, (k % 2 == 0));
         checkOutput("rr_drain_ivalid", c.ibus_rsp_valid, (k % 2 == 1));
         if (k % 2 == 0) checkOutput("rr_drain_ddata", c.dbus_rsp_data, 32'h1000 + k);
         else            checkOutput("rr_drain_iinst", c.ibus_rsp_inst, 32'h1000 + k);
      end
      m.m_rsp_valid = 1'b0;
      tick;
      checkOutput("drain_idle", c.dbus_rsp_valid | c.ibus_rsp_valid, 0);

      // Single fetch at 0x100, downstream answers three cycles later.
      applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
      #1;
      checkOutput("fetch_mreq_valid", m.m_req_valid, 1);
      checkOutput("fetch_addr", m.m_req_addr, 32'h100);
      checkOutput("fetch_wstrb", m.m_req_wstrb, 4'hF);
      checkOutput("fetch_we", m.m_req_we, 0);
      checkOutput("fetch_ready", c.ibus_cmd_ready, 1);
      tick;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick;
      tick;
      m.m_rsp_valid = 1'b1;
      m.m_rsp_rdata = 32'h13;
      #1;
      checkOutput("fetch_rsp_early", c.ibus_rsp_valid, 0);
      tick;
      m.m_rsp_valid = 1'b0;
      checkOutput("fetch_rsp_valid", c.ibus_rsp_valid, 1);
      checkOutput("fetch_rsp_inst", c.ibus_rsp_inst, 32'h13);
      checkOutput("fetch_rsp_err", c.ibus_rsp_error, 0);
      tick;
      checkOutput("fetch_rsp_pulse", c.ibus_rsp_valid, 0);

      // Byte write to 0x203 and half write to 0x206; writes never answer the core.
      applyStimulus(0, 0, 1, 1, 32'h203, 32'hAB, 0);
      #1;
      checkOutput("bwr_wdata", m.m_req_wdata, 32'hABABABAB);
      checkOutput("bwr_wstrb", m.m_req_wstrb, 4'b1000);
      checkOutput("bwr_we", m.m_req_we, 1);
      checkOutput("bwr_addr", m.m_req_addr, 32'h203);
      tick;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      m.m_rsp_valid = 1'b1;
      tick;
      m.m_rsp_valid = 1'b0;
      checkOutput("bwr_no_rsp", c.dbus_rsp_valid, 0);
      checkOutput("bwr_not_spurious", errSpurious, 0);
      applyStimulus(0, 0, 1, 1, 32'h206, 32'h1234, 1);
      #1;
      checkOutput("hwr_wdata", m.m_req_wdata, 32'h12341234);
      checkOutput("hwr_wstrb", m.m_req_wstrb, 4'b1100);
      tick;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      m.m_rsp_valid = 1'b1;
      tick;
      m.m_rsp_valid = 1'b0;
      checkOutput("hwr_no_rsp", c.dbus_rsp_valid, 0);
      checkOutput("hwr_not_spurious", errSpurious, 0);

      // Six reads with no responses: only four fit; one response frees one slot.
      applyStimulus(0, 0, 1, 0, 32'h300, 0, 2);
      accepted = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (c.dbus_cmd_ready) accepted++;
         tick;
      end
      checkOutput("limit_accepts", accepted, 4);
      #1;
      checkOutput("limit_ready", c.dbus_cmd_ready, 0);
      checkOutput("limit_mreq", m.m_req_valid, 0);
      m.m_rsp_valid = 1'b1;
      m.m_rsp_rdata = 32'h55;
      #1;
      checkOutput("prepop_ready", c.dbus_cmd_ready, 0);
      tick;
      m.m_rsp_valid = 1'b0;
      checkOutput("limit_rsp_valid", c.dbus_rsp_valid, 1);
      checkOutput("limit_rsp_data", c.dbus_rsp_data, 32'h55);
      #1;
      checkOutput("slot_freed", c.dbus_cmd_ready, 1);
      tick;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         m.m_rsp_valid = 1'b1;
         tick;
      end
      m.m_rsp_valid = 1'b0;
      tick;

      // Out-of-window read queued behind two legal reads comes back third, as an error.
      applyStimulus(0, 0, 1, 0, 32'h10, 0, 2);
      tick;
      applyStimulus(0, 0, 1, 0, 32'h14, 0, 2);
      tick;
      applyStimulus(0, 0, 1, 0, 32'h9000_0000, 0, 2);
      #1;
      checkOutput("illrd_mreq", m.m_req_valid, 0);
      checkOutput("illrd_ready", c.dbus_cmd_ready, 1);
      tick;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      m.m_rsp_valid = 1'b1;
      m.m_rsp_rdata = 32'hA1;
      tick;
      checkOutput("ord1_valid", c.dbus_rsp_valid, 1);
      checkOutput("ord1_data", c.dbus_rsp_data, 32'hA1);
      checkOutput("ord1_err", c.dbus_rsp_error, 0);
      m.m_rsp_rdata = 32'hA2;
      m.m_rsp_error = 1'b1;
      tick;
      m.m_rsp_valid = 1'b0;
      m.m_rsp_error = 1'b0;
      checkOutput("ord2_data", c.dbus_rsp_data, 32'hA2);
      checkOutput("ord2_err", c.dbus_rsp_error, 1);
      tick;
      checkOutput("ord3_valid", c.dbus_rsp_valid, 1);
      checkOutput("ord3_err", c.dbus_rsp_error, 1);
      checkOutput("ord3_data", c.dbus_rsp_data, 0);
      tick;
      checkOutput("ord_idle", c.dbus_rsp_valid, 0);

      // Out-of-window write is swallowed and flagged.
      applyStimulus(0, 0, 1, 1, 32'h9000_0000, 32'hDEAD, 2);
      #1;
      checkOutput("illwr_mreq", m.m_req_valid, 0);
      checkOutput("illwr_ready", c.dbus_cmd_ready, 1);
      tick;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("illwr_drop_pulse", errWrDrop, 1);
      tick;
      checkOutput("illwr_drop_end", errWrDrop, 0);
      checkOutput("illwr_no_rsp", c.dbus_rsp_valid, 0);

      // Interrupt latency: ext through two flops, timer and sw through one.
      irqExt   = 1'b1;
      irqTimer = 1'b1;
      irqSw    = 1'b1;
      tick;
      checkOutput("irq_ext_1", irqExtOut, 0);
      checkOutput("irq_timer_1", irqTimerOut, 1);
      checkOutput("irq_sw_1", irqSwOut, 1);
      tick;
      checkOutput("irq_ext_2", irqExtOut, 1);

      // Reset with three reads in flight; a later downstream response is spurious.
      applyStimulus(0, 0, 1, 0, 32'h20, 0, 2);
      tick;
      tick;
      tick;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      arst = 1'b0;
      #1;
      checkOutput("arst_irq_ext", irqExtOut, 0);
      checkOutput("arst_irq_timer", irqTimerOut, 0);
      checkOutput("arst_irq_sw", irqSwOut, 0);
      checkOutput("arst_dbus_rsp", c.dbus_rsp_valid, 0);
      checkOutput("arst_ibus_rsp", c.ibus_rsp_valid, 0);
      checkOutput("arst_errs", errWrDrop | errSpurious, 0);
      irqExt   = 1'b0;
      irqTimer = 1'b0;
      irqSw    = 1'b0;
      tick;
      #2 arst = 1'b1;
      tick;
      m.m_rsp_valid = 1'b1;
      m.m_rsp_rdata = 32'h77;
      tick;
      m.m_rsp_valid = 1'b0;
      checkOutput("post_rst_spurious", errSpurious, 1);
      checkOutput("post_rst_dbus_rsp", c.dbus_rsp_valid, 0);
      checkOutput("post_rst_ibus_rsp", c.ibus_rsp_valid, 0);
      tick;
      checkOutput("post_rst_spurious_end", errSpurious, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
